// File: rtl/poker_pkg.sv
// poker_pkg: screen state encoding, keyboard codes and pixel colour type shared by the screen sequencer
package poker_pkg;
  typedef enum logic [1:0] {
    S_START      = 2'd0,
    S_TRANSITION = 2'd1,
    S_GAME       = 2'd2
  } screen_t;
  localparam logic [7:0] KEY_ENTER_CODE = 8'h28;
  localparam logic [7:0] KEY_ESC_CODE = 8'h29;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;
  function automatic logic [3:0] sat_sub4(input logic [3:0] a, input logic [3:0] b);
    return a > b ? a - b : 4'd0;
  endfunction
endpackage

// File: rtl/screen_sequencer_key_edge_detect.sv
// key_edge_detect: turns a held HID keycode into single-cycle ENTER/ESC press events
module key_edge_detect
  import poker_pkg::*;
#(
  parameter logic [7:0] ENTER_CODE = KEY_ENTER_CODE,
  parameter logic [7:0] ESC_CODE = KEY_ESC_CODE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] keycode_i,
  output logic       enter_evt_o,
  output logic       esc_evt_o
);
  logic [7:0] keycode_q;
  // previous keycode, so a held key only fires on its first cycle
  always_ff @(posedge clk) begin
    keycode_q <= reset ? 8'd0 : keycode_i;
  end
  assign enter_evt_o = (keycode_i == ENTER_CODE) && (keycode_q != ENTER_CODE);
  assign esc_evt_o = (keycode_i == ESC_CODE) && (keycode_q != ESC_CODE);
endmodule

// File: rtl/screen_sequencer.sv
// screen_sequencer: frame-aligned START/TRANSITION/GAME screen FSM with font ROM and RGB muxing; SCREEN_FADE_EN enables a fade-out during TRANSITION
module screen_sequencer
  import poker_pkg::*;
#(
  parameter int unsigned BLANK_FRAMES = 30,
  parameter logic [7:0]  KEY_ENTER = KEY_ENTER_CODE,
  parameter logic [7:0]  KEY_ESC = KEY_ESC_CODE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  keycode,
  input  logic        frame_start,
  input  logic [10:0] start_font_address,
  input  logic [3:0]  start_red,
  input  logic [3:0]  start_green,
  input  logic [3:0]  start_blue,
  input  logic [10:0] game_font_address,
  input  logic [3:0]  game_red,
  input  logic [3:0]  game_green,
  input  logic [3:0]  game_blue,
  output logic [10:0] font_address,
  output logic [3:0]  Red,
  output logic [3:0]  Green,
  output logic [3:0]  Blue,
  output logic [1:0]  screen_state,
  output logic        new_game
);
  localparam logic [7:0] LAST_FRAME = 8'(BLANK_FRAMES - 1);
  screen_t    state_q, state_d;
  logic       enter_pend_q, enter_pend_d;
  logic       esc_pend_q, esc_pend_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       new_game_q, new_game_d;
  logic       enter_evt, esc_evt;
  rgb_t       start_rgb, game_rgb, trans_rgb, pix;
  key_edge_detect #(
    .ENTER_CODE(KEY_ENTER),
    .ESC_CODE  (KEY_ESC)
  ) u_keys (
    .clk        (clk),
    .reset      (reset),
    .keycode_i  (keycode),
    .enter_evt_o(enter_evt),
    .esc_evt_o  (esc_evt)
  );
  // state register plus pending requests, blank-frame counter and new_game pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_START;
      enter_pend_q <= 1'b0;
      esc_pend_q   <= 1'b0;
      frame_cnt_q  <= 8'd0;
      new_game_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      enter_pend_q <= enter_pend_d;
      esc_pend_q   <= esc_pend_d;
      frame_cnt_q  <= frame_cnt_d;
      new_game_q   <= new_game_d;
    end
  end
  // next state: key presses are latched as pending and honoured at the next frame_start
  always_comb begin
    state_d      = state_q;
    enter_pend_d = enter_pend_q;
    esc_pend_d   = esc_pend_q;
    frame_cnt_d  = frame_cnt_q;
    new_game_d   = 1'b0;
    case (state_q)
      S_START:
        if (frame_start && (enter_pend_q || enter_evt)) begin
          state_d      = S_TRANSITION;
          frame_cnt_d  = 8'd0;
          enter_pend_d = 1'b0;
        end else if (enter_evt) enter_pend_d = 1'b1;
      S_TRANSITION:
        if (frame_start) begin
          if (frame_cnt_q == LAST_FRAME) begin
            state_d     = S_GAME;
            frame_cnt_d = 8'd0;
            new_game_d  = 1'b1;
          end else frame_cnt_d = frame_cnt_q + 8'd1;
        end
      S_GAME:
        if (frame_start && (esc_pend_q || esc_evt)) begin
          state_d    = S_START;
          esc_pend_d = 1'b0;
        end else if (esc_evt) esc_pend_d = 1'b1;
      default: begin
        state_d      = S_START;
        enter_pend_d = 1'b0;
        esc_pend_d   = 1'b0;
        frame_cnt_d  = 8'd0;
      end
    endcase
  end
  assign start_rgb = {start_red, start_green, start_blue};
  assign game_rgb = {game_red, game_green, game_blue};
`ifdef SCREEN_FADE_EN
  logic [3:0]  fade_lvl_q, fade_lvl_d;
  logic [11:0] fade_raw;
  // fade level is refreshed once per frame from the counter value that frame will show
  always_comb begin
    fade_raw   = {frame_cnt_d, 4'd0} / 12'(BLANK_FRAMES);
    fade_lvl_d = frame_start ? (fade_raw > 12'd15 ? 4'hF : fade_raw[3:0]) : fade_lvl_q;
  end
  // fade level register
  always_ff @(posedge clk) begin
    fade_lvl_q <= reset ? 4'd0 : fade_lvl_d;
  end
  assign trans_rgb = {sat_sub4(start_red, fade_lvl_q), sat_sub4(start_green, fade_lvl_q),
                      sat_sub4(start_blue, fade_lvl_q)};
`else
  assign trans_rgb = '0;
`endif
  // output mux from registered state; purely combinational so font ROM timing is unchanged
  always_comb begin
    font_address = state_q == S_GAME ? game_font_address :
                   (state_q == S_START || state_q == S_TRANSITION) ? start_font_address : 11'd0;
    pix = state_q == S_START ? start_rgb :
          state_q == S_GAME ? game_rgb :
          state_q == S_TRANSITION ? trans_rgb : '0;
  end
  assign {Red, Green, Blue} = pix;
  assign screen_state = state_q;
  assign new_game = new_game_q;
endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: directed scenarios plus random keys/frames checked against a behavioural screen model
module tb_screen_sequencer;
  localparam int BF = 3;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  keycode = 8'd0;
  logic        frame_start = 1'b0;
  logic [10:0] start_font_address = 11'h123;
  logic [3:0]  start_red = 4'h5, start_green = 4'h6, start_blue = 4'h7;
  logic [10:0] game_font_address = 11'h456;
  logic [3:0]  game_red = 4'h1, game_green = 4'h2, game_blue = 4'h3;
  logic [10:0] font_address;
  logic [3:0]  Red, Green, Blue;
  logic [1:0]  screen_state;
  logic        new_game;
  int total = 0, bad = 0, ng_seen = 0;
  int m_mode = 0, m_prev = 0, m_done = 0;
  bit m_ep = 0, m_xp = 0, m_ng = 0;
`ifdef SCREEN_FADE_EN
  int m_fade = 0;
`endif
  screen_sequencer #(.BLANK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .keycode(keycode), .frame_start(frame_start),
    .start_font_address(start_font_address), .start_red(start_red), .start_green(start_green),
    .start_blue(start_blue), .game_font_address(game_font_address), .game_red(game_red),
    .game_green(game_green), .game_blue(game_blue), .font_address(font_address), .Red(Red),
    .Green(Green), .Blue(Blue), .screen_state(screen_state), .new_game(new_game)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_edge();
    bit en, es;
    en = keycode == 8'h28 && m_prev != 8'h28;
    es = keycode == 8'h29 && m_prev != 8'h29;
    m_ng = 0;
    if (reset) begin
      m_mode = 0; m_prev = 0; m_ep = 0; m_xp = 0; m_done = 0;
`ifdef SCREEN_FADE_EN
      m_fade = 0;
`endif
      return;
    end
    if (m_mode == 0) begin
      if (frame_start && (m_ep || en)) begin m_mode = 1; m_ep = 0; m_done = 0; end
      else if (en) m_ep = 1;
    end else if (m_mode == 1) begin
      if (frame_start) begin
        m_done++;
        if (m_done == BF) begin m_mode = 2; m_done = 0; m_ng = 1; end
      end
    end else begin
      if (frame_start && (m_xp || es)) begin m_mode = 0; m_xp = 0; end
      else if (es) m_xp = 1;
    end
`ifdef SCREEN_FADE_EN
    if (frame_start) m_fade = (m_done * 16 / BF > 15) ? 15 : m_done * 16 / BF;
`endif
    m_prev = keycode;
  endtask
`ifdef SCREEN_FADE_EN
  function automatic int dim(input int c);
    return c > m_fade ? c - m_fade : 0;
  endfunction
`endif
  function automatic int exp_rgb();
    if (m_mode == 0) return {20'd0, start_red, start_green, start_blue};
    if (m_mode == 2) return {20'd0, game_red, game_green, game_blue};
`ifdef SCREEN_FADE_EN
    return dim(start_red) * 256 + dim(start_green) * 16 + dim(start_blue);
`else
    return 0;
`endif
  endfunction
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("state", screen_state, m_mode);
    check("new_game", new_game, m_ng);
    check("font", font_address, m_mode == 2 ? game_font_address : start_font_address);
    check("rgb", {Red, Green, Blue}, exp_rgb());
    if (new_game) ng_seen++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic frame(input int n);
    idle(n);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask
  initial begin
    idle(2);
    check("rst_state", screen_state, 0);
    check("rst_new_game", new_game, 0);
    reset = 1'b0;
    ng_seen = 0;
    keycode = 8'h28;
    frame(4);
    check("held_enter_trans", screen_state, 1);
    frame(4);
    frame(4);
    check("held_still_trans", screen_state, 1);
    frame(4);
    check("held_game", screen_state, 2);
    check("held_pulse", new_game, 1);
    frame(4);
    check("held_one_pulse", ng_seen, 1);
    check("held_stays_game", screen_state, 2);
    keycode = 8'h29;
    step();
    keycode = 8'h00;
    frame(3);
    check("esc_pending_start", screen_state, 0);
    keycode = 8'h28;
    step();
    keycode = 8'h00;
    idle(99);
    check("midframe_wait", screen_state, 0);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("midframe_trans", screen_state, 1);
`ifndef SCREEN_FADE_EN
    check("trans_black", {Red, Green, Blue}, 0);
`endif
    frame(2); frame(2); frame(2);
    keycode = 8'h29;
    step();
    keycode = 8'h00;
    frame(2);
    keycode = 8'h28;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    keycode = 8'h00;
    check("same_cycle_trans", screen_state, 1);
    frame(2); frame(2); frame(2);
    game_font_address = 11'h510;
    game_red = 4'hA;
    step();
    check("game_font", font_address, 11'h510);
    check("game_red", Red, 4'hA);
    keycode = 8'h29;
    step();
    frame(2);
    check("esc_start", screen_state, 0);
    check("esc_font", font_address, 11'h123);
    check("esc_red", Red, 4'h5);
    keycode = 8'h28;
    frame(2);
    keycode = 8'h00;
    frame(2); frame(2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midtrans_rst_state", screen_state, 0);
    check("midtrans_rst_ng", new_game, 0);
    frame(3);
    check("rst_no_enter", screen_state, 0);
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 299) == 0;
      frame_start = $urandom_range(0, 5) == 0;
      if ($urandom_range(0, 3) == 0)
        case ($urandom_range(0, 3))
          0: keycode = 8'h00;
          1: keycode = 8'h28;
          2: keycode = 8'h29;
          default: keycode = 8'($urandom);
        endcase
      start_font_address = 11'($urandom);
      game_font_address = 11'($urandom);
      {start_red, start_green, start_blue} = 12'($urandom);
      {game_red, game_green, game_blue} = 12'($urandom);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
